// File: rtl/rv32i_pkg.sv
// Shared LSU types: FSM state encoding, exception bit positions and funct3 helpers.
package rv32i_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    // Bit positions inside rsp_exc = {access_fault, store_misaligned, load_misaligned}
    localparam int LSU_EXC_LOAD_MISALIGNED  = 0;
    localparam int LSU_EXC_STORE_MISALIGNED = 1;
    localparam int LSU_EXC_ACCESS_FAULT     = 2;

    localparam logic [1:0] LSU_SIZE_B = 2'd0;
    localparam logic [1:0] LSU_SIZE_H = 2'd1;
    localparam logic [1:0] LSU_SIZE_W = 2'd2;

    // funct3 3, 6 and 7 have no RV32I load/store meaning and are reported as faults.
    function automatic logic funct3_legal(input logic [2:0] funct3);
        return !((funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational address generation, misalignment/fault decode and store-lane placement.
module lsu_align
    import rv32i_pkg::*;
#(
    parameter int MEM_WIDTH = 15,
    parameter int XLEN      = 32
) (
    input  logic [XLEN-1:0] base_i,
    input  logic [XLEN-1:0] offset_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [2:0]      funct3_i,
    input  logic            is_store_i,
    output logic [XLEN-1:0] ea_o,
    output logic [2:0]      exc_o,
    output logic [63:0]     wr_data_o
);

    logic legal;
    logic misaligned;
    logic fault;

    assign ea_o  = base_i + offset_i;
    assign legal = funct3_legal(funct3_i);

    // Byte accesses can never misalign; illegal codes report only the fault.
    assign misaligned = legal &&
                        (((funct3_i[1:0] == LSU_SIZE_H) && ea_o[0]) ||
                         ((funct3_i[1:0] == LSU_SIZE_W) && (ea_o[1:0] != 2'b00)));

    assign fault = !legal || ((ea_o >> MEM_WIDTH) != '0);

    always_comb begin
        exc_o = '0;
        exc_o[LSU_EXC_ACCESS_FAULT]     = fault;
        exc_o[LSU_EXC_STORE_MISALIGNED] = misaligned & is_store_i;
        exc_o[LSU_EXC_LOAD_MISALIGNED]  = misaligned & ~is_store_i;
    end

    assign wr_data_o = 64'(wdata_i) << {ea_o[2:0], 3'b000};

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one execute-stage request, performs a single memory
// access cycle and holds the writeback response until it is taken.
//
//   state  | meaning
//   IDLE   | req_ready=1, waiting for a request
//   ACCESS | one cycle driving memory address/strobe from latched request
//   RESP   | rsp_valid=1, outputs held until rsp_ready
module lsu
    import rv32i_pkg::*;
#(
    parameter int MEM_WIDTH = 15,
    parameter int XLEN      = 32
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_is_store,
    input  logic [2:0]           req_funct3,
    input  logic [XLEN-1:0]      req_base,
    input  logic [XLEN-1:0]      req_offset,
    input  logic [XLEN-1:0]      req_wdata,
    input  logic [4:0]           req_rd,
    output logic [2:0]           mem_funct3,
    output logic [MEM_WIDTH-1:0] mem_rd_addr,
    output logic [MEM_WIDTH-1:0] mem_wr_addr,
    input  logic [63:0]          mem_rd_data,
    output logic [63:0]          mem_wr_data,
    output logic                 mem_wr_en,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4:0]           rsp_rd,
    output logic [XLEN-1:0]      rsp_data,
    output logic [2:0]           rsp_exc,
    output logic [XLEN-1:0]      rsp_exc_addr
);

    lsu_state_t state_q, state_d;

    logic                 is_store_q, is_store_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [MEM_WIDTH-1:0] addr_q, addr_d;
    logic [63:0]          wr_data_q, wr_data_d;
    logic [4:0]           rsp_rd_q, rsp_rd_d;
    logic [XLEN-1:0]      rsp_data_q, rsp_data_d;
    logic [2:0]           rsp_exc_q, rsp_exc_d;
    logic [XLEN-1:0]      rsp_exc_addr_q, rsp_exc_addr_d;

    logic [XLEN-1:0]      align_ea;
    logic [2:0]           align_exc;
    logic [63:0]          align_wr_data;
    logic                 unused_rd_hi;

    assign unused_rd_hi = ^mem_rd_data[63:XLEN];

    lsu_align #(
        .MEM_WIDTH (MEM_WIDTH),
        .XLEN      (XLEN)
    ) u_align (
        .base_i     (req_base),
        .offset_i   (req_offset),
        .wdata_i    (req_wdata),
        .funct3_i   (req_funct3),
        .is_store_i (req_is_store),
        .ea_o       (align_ea),
        .exc_o      (align_exc),
        .wr_data_o  (align_wr_data)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q        <= IDLE;
            is_store_q     <= 1'b0;
            funct3_q       <= '0;
            addr_q         <= '0;
            wr_data_q      <= '0;
            rsp_rd_q       <= '0;
            rsp_data_q     <= '0;
            rsp_exc_q      <= '0;
            rsp_exc_addr_q <= '0;
        end else begin
            state_q        <= state_d;
            is_store_q     <= is_store_d;
            funct3_q       <= funct3_d;
            addr_q         <= addr_d;
            wr_data_q      <= wr_data_d;
            rsp_rd_q       <= rsp_rd_d;
            rsp_data_q     <= rsp_data_d;
            rsp_exc_q      <= rsp_exc_d;
            rsp_exc_addr_q <= rsp_exc_addr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        is_store_d     = is_store_q;
        funct3_d       = funct3_q;
        addr_d         = addr_q;
        wr_data_d      = wr_data_q;
        rsp_rd_d       = rsp_rd_q;
        rsp_data_d     = rsp_data_q;
        rsp_exc_d      = rsp_exc_q;
        rsp_exc_addr_d = rsp_exc_addr_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    is_store_d     = req_is_store;
                    funct3_d       = req_funct3;
                    addr_d         = align_ea[MEM_WIDTH-1:0];
                    wr_data_d      = align_wr_data;
                    // Stores have no writeback target, so rd is reported as x0.
                    rsp_rd_d       = req_is_store ? 5'd0 : req_rd;
                    rsp_data_d     = '0;
                    rsp_exc_d      = align_exc;
                    rsp_exc_addr_d = (align_exc != 3'b000) ? align_ea : '0;
                    state_d        = (align_exc != 3'b000) ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (!is_store_q) begin
                    rsp_data_d = mem_rd_data[XLEN-1:0];
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready    = (state_q == IDLE);
    assign rsp_valid    = (state_q == RESP);
    assign mem_wr_en    = (state_q == ACCESS) && is_store_q;
    assign mem_wr_data  = mem_wr_en ? wr_data_q : '0;
    assign mem_rd_addr  = addr_q;
    assign mem_wr_addr  = addr_q;
    assign mem_funct3   = funct3_q;
    assign rsp_rd       = rsp_rd_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_exc      = rsp_exc_q;
    assign rsp_exc_addr = rsp_exc_addr_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: a byte-array reference model predicts responses and
// store strobes; a negedge monitor compares whatever the DUT presents.
module tb_lsu;

    localparam int MW = 15;
    localparam int XL = 32;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_is_store = 1'b0;
    logic [2:0]    req_funct3 = '0;
    logic [XL-1:0] req_base = '0;
    logic [XL-1:0] req_offset = '0;
    logic [XL-1:0] req_wdata = '0;
    logic [4:0]    req_rd = '0;
    logic [2:0]    mem_funct3;
    logic [MW-1:0] mem_rd_addr;
    logic [MW-1:0] mem_wr_addr;
    logic [63:0]   mem_rd_data;
    logic [63:0]   mem_wr_data;
    logic          mem_wr_en;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [4:0]    rsp_rd;
    logic [XL-1:0] rsp_data;
    logic [2:0]    rsp_exc;
    logic [XL-1:0] rsp_exc_addr;

    lsu #(.MEM_WIDTH(MW), .XLEN(XL)) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_base     (req_base),
        .req_offset   (req_offset),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .mem_funct3   (mem_funct3),
        .mem_rd_addr  (mem_rd_addr),
        .mem_wr_addr  (mem_wr_addr),
        .mem_rd_data  (mem_rd_data),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_en    (mem_wr_en),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rd       (rsp_rd),
        .rsp_data     (rsp_data),
        .rsp_exc      (rsp_exc),
        .rsp_exc_addr (rsp_exc_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [2:0]  exc;
        logic [31:0] exc_addr;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [14:0] addr;
        logic [63:0] data;
        logic [2:0]  f3;
    } wr_t;

    rsp_t exp_rsp[$];
    wr_t  exp_wr[$];

    logic [7:0] dmem    [0:32767];
    logic [7:0] ref_mem [0:32767];

    int n_tests = 0;
    int n_fail  = 0;
    int rr_mode = 0;   // 0: always ready, 1: random, 2: held low

    logic [63:0] last_wr_data = '0;
    logic [31:0] last_rsp_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [63:0] extend(input logic [31:0] raw, input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return f3[2] ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            2'd1:    return f3[2] ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            default: return f3[2] ? {32'd0, raw}       : {{32{raw[31]}}, raw};
        endcase
    endfunction

    // Memory side: compacted/extended read data, byte-lane write on strobe.
    always_comb begin
        mem_rd_data = extend({dmem[15'(mem_rd_addr + 15'd3)], dmem[15'(mem_rd_addr + 15'd2)],
                              dmem[15'(mem_rd_addr + 15'd1)], dmem[mem_rd_addr]}, mem_funct3);
    end

    initial begin
        for (int i = 0; i < 32768; i++) begin
            dmem[i]    = 8'($urandom);
            ref_mem[i] = dmem[i];
        end
        forever begin
            @(posedge clk);
            if (mem_wr_en) begin
                for (int i = 0; i < (1 << mem_funct3[1:0]); i++) begin
                    dmem[15'(mem_wr_addr + 15'(i))] = mem_wr_data[8*int'(3'(mem_wr_addr[2:0] + 3'(i))) +: 8];
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rr_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ($urandom_range(0, 3) != 0);
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Reference model: predicts exception, writeback data and the store strobe.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] wd, input logic [4:0] rd);
        logic [31:0] ea;
        logic        legal, mis, fault;
        logic [2:0]  exc;
        logic [63:0] ld;
        rsp_t        r;
        wr_t         w;
        int          n, waitc;
        ea    = base + off;
        legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        n     = 1 << f3[1:0];
        mis   = legal && ((ea & 32'(n - 1)) != 0);
        fault = !legal || (ea >= (32'd1 << MW));
        exc   = {fault, mis && st, mis && !st};
        waitc = 0;
        while (!req_ready) begin
            @(posedge clk);
            #1;
            waitc++;
            if (waitc > 50) begin
                fail_now("req_ready_timeout");
                return;
            end
        end
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_base     = base;
        req_offset   = off;
        req_wdata    = wd;
        req_rd       = rd;
        r.cyc      = cyc + ((exc != 3'b000) ? 1 : 2);
        r.rd       = st ? 5'd0 : rd;
        r.exc      = exc;
        r.exc_addr = (exc != 3'b000) ? ea : 32'd0;
        r.data     = 32'd0;
        if (exc == 3'b000 && !st) begin
            ld = extend({ref_mem[15'(ea + 32'd3)], ref_mem[15'(ea + 32'd2)],
                         ref_mem[15'(ea + 32'd1)], ref_mem[15'(ea)]}, f3);
            r.data = ld[31:0];
        end
        if (exc == 3'b000 && st) begin
            for (int i = 0; i < n; i++) ref_mem[15'(ea + 32'(i))] = wd[8*i +: 8];
            w.addr = ea[14:0];
            w.data = 64'(wd) << (8 * ea[2:0]);
            w.f3   = f3;
            exp_wr.push_back(w);
        end
        exp_rsp.push_back(r);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int waitc;
        waitc = 0;
        while (exp_rsp.size() != 0) begin
            @(posedge clk);
            #1;
            waitc++;
            if (waitc > 200) begin
                fail_now("drain_timeout");
                exp_rsp.delete();
                exp_wr.delete();
            end
        end
    endtask

    // Monitor
    logic        in_rsp = 1'b0;
    int          first_cyc = 0;
    logic [4:0]  h_rd;
    logic [31:0] h_data, h_exc_addr;
    logic [2:0]  h_exc;
    rsp_t        mr;
    wr_t         mw;

    initial begin
        forever begin
            @(negedge clk);
            if (aresetn) begin
                if (mem_wr_en) begin
                    if (exp_wr.size() == 0) begin
                        fail_now("unexpected_mem_wr_en");
                    end else begin
                        mw = exp_wr.pop_front();
                        check("wr_addr", 64'(mem_wr_addr), 64'(mw.addr));
                        check("wr_data", mem_wr_data, mw.data);
                        check("wr_funct3", 64'(mem_funct3), 64'(mw.f3));
                        last_wr_data = mem_wr_data;
                    end
                end else if (mem_wr_data != 64'd0) begin
                    fail_now("wr_data_nonzero_idle");
                end
                if (rsp_valid) begin
                    if (req_ready) fail_now("req_ready_during_rsp");
                    if (!in_rsp) begin
                        in_rsp     = 1'b1;
                        first_cyc  = cyc;
                        h_rd       = rsp_rd;
                        h_data     = rsp_data;
                        h_exc      = rsp_exc;
                        h_exc_addr = rsp_exc_addr;
                    end else begin
                        check("stable_rsp", {rsp_data, rsp_exc_addr}, {h_data, h_exc_addr});
                        check("stable_rd_exc", 64'({rsp_rd, rsp_exc}), 64'({h_rd, h_exc}));
                    end
                    if (rsp_ready) begin
                        if (exp_rsp.size() == 0) begin
                            fail_now("unexpected_rsp");
                        end else begin
                            mr = exp_rsp.pop_front();
                            check("rsp_rd", 64'(rsp_rd), 64'(mr.rd));
                            check("rsp_data", 64'(rsp_data), 64'(mr.data));
                            check("rsp_exc", 64'(rsp_exc), 64'(mr.exc));
                            check("rsp_exc_addr", 64'(rsp_exc_addr), 64'(mr.exc_addr));
                            check("rsp_latency", 64'(first_cyc), 64'(mr.cyc));
                            last_rsp_data = rsp_data;
                        end
                        in_rsp = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int waitc;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_rd", 64'(rsp_rd), 64'd0);
        check("rst_rsp_exc", 64'(rsp_exc), 64'd0);
        check("rst_rsp_exc_addr", 64'(rsp_exc_addr), 64'd0);
        check("rst_mem_addr", 64'({mem_rd_addr, mem_wr_addr}), 64'd0);
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        check("req_ready_after_rst", 64'(req_ready), 64'd1);

        // Directed: SW, SB then LB of the same byte, misaligned LW, faulting SH.
        issue(1'b1, 3'd2, 32'h100, 32'd4, 32'hDEADBEEF, 5'd3);
        drain();
        check("sw_wr_data", last_wr_data, 64'hDEADBEEF_00000000);
        issue(1'b1, 3'd0, 32'h103, 32'd0, 32'h000000AB, 5'd4);
        drain();
        check("sb_wr_data", last_wr_data, 64'h00000000_AB000000);
        issue(1'b0, 3'd0, 32'h103, 32'd0, 32'd0, 5'd5);
        drain();
        check("lb_rsp_data", 64'(last_rsp_data), 64'hFFFFFFAB);
        issue(1'b0, 3'd2, 32'h102, 32'd0, 32'd0, 5'd6);
        drain();
        issue(1'b1, 3'd1, 32'h0001_0000, 32'd0, 32'h1234, 5'd7);
        drain();

        // Hold rsp_ready low for five RESP cycles, then release.
        rr_mode = 2;
        @(posedge clk);
        #1;
        issue(1'b0, 3'd2, 32'h100, 32'd0, 32'd0, 5'd9);
        waitc = 0;
        while (!rsp_valid && waitc < 20) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("stall_req_ready", 64'(req_ready), 64'd0);
            check("stall_rsp_valid_held", 64'(rsp_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        rr_mode = 0;
        @(posedge clk);
        #1;
        check("release_req_ready", 64'(req_ready), 64'd1);
        issue(1'b0, 3'd4, 32'h101, 32'd0, 32'd0, 5'd10);
        drain();

        // Reset asserted while a store is in ACCESS.
        issue(1'b1, 3'd2, 32'h7F00, 32'd0, 32'hCAFEF00D, 5'd0);
        check("abort_wr_en_before", 64'(mem_wr_en), 64'd1);
        #1;
        aresetn = 1'b0;
        #1;
        check("abort_wr_en", 64'(mem_wr_en), 64'd0);
        check("abort_wr_data", mem_wr_data, 64'd0);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        exp_rsp.delete();
        exp_wr.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        in_rsp  = 1'b0;
        @(posedge clk);
        #1;
        check("abort_idle_ready", 64'(req_ready), 64'd1);
        check("abort_idle_rsp_valid", 64'(rsp_valid), 64'd0);

        // Randomized traffic with random writeback backpressure.
        rr_mode = 1;
        for (int t = 0; t < 300; t++) begin
            logic [31:0] b, o;
            b = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
            o = 32'($urandom_range(0, 64)) - 32'd32;
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), b, o, $urandom,
                  5'($urandom_range(0, 31)));
        end
        rr_mode = 0;
        drain();
        repeat (3) @(posedge clk);
        if (exp_wr.size() != 0) fail_now("store_strobes_missing");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
